// File: rtl/id_pkg.sv
// Decode-stage package: opcode/funct encodings, control bundle layout and the
// decode / register-usage tables shared by id_stage_hz.
package id_pkg;

   localparam int NB_CTRL = 18;

   // Bit positions inside the control bundle (MSB first).
   localparam int CTRL_REG_DEST   = 17;
   localparam int CTRL_ALU_OP_LSB = 11;
   localparam int CTRL_ALU_SRC    = 10;
   localparam int CTRL_MEM_RD     = 9;
   localparam int CTRL_MEM_WR     = 8;
   localparam int CTRL_BRANCH     = 7;
   localparam int CTRL_REG_WR     = 6;
   localparam int CTRL_MEM_TO_REG = 5;
   localparam int CTRL_JUMP       = 4;
   localparam int CTRL_JR_JALR    = 3;
   localparam int CTRL_BYTE       = 2;
   localparam int CTRL_HALF       = 1;
   localparam int CTRL_WORD       = 0;

   typedef logic [NB_CTRL-1:0] ctrl_t;
   localparam ctrl_t CTRL_BUBBLE = '0;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                          OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                          OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                          OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E,
                          OP_LUI   = 6'h0F, OP_LB   = 6'h20, OP_LH    = 6'h21,
                          OP_LW    = 6'h23, OP_LBU  = 6'h24, OP_LHU   = 6'h25,
                          OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                          FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                          FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20,
                          FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                          FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26,
                          FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

   function automatic logic rtype_known(input logic [5:0] fn);
      case (fn)
         FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_JALR,
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
         FN_SLT, FN_SLTU: return 1'b1;
         default:         return 1'b0;
      endcase
   endfunction

   // alu_op carries funct for R-type and the opcode for everything else.
   function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] fn);
      ctrl_t c;
      c = CTRL_BUBBLE;
      case (op)
         OP_RTYPE: begin
            if (rtype_known(fn)) begin
               c[CTRL_ALU_OP_LSB +: 6] = fn;
               c[CTRL_JR_JALR]         = (fn == FN_JR) || (fn == FN_JALR);
               c[CTRL_REG_DEST]        = (fn != FN_JR);
               c[CTRL_REG_WR]          = (fn != FN_JR);
            end
         end
         OP_J, OP_JAL: begin
            c[CTRL_ALU_OP_LSB +: 6] = op;
            c[CTRL_JUMP]            = 1'b1;
            c[CTRL_REG_WR]          = (op == OP_JAL);
         end
         OP_BEQ, OP_BNE: begin
            c[CTRL_ALU_OP_LSB +: 6] = op;
            c[CTRL_BRANCH]          = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            c[CTRL_ALU_OP_LSB +: 6] = op;
            c[CTRL_ALU_SRC]         = 1'b1;
            c[CTRL_REG_WR]          = 1'b1;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            c[CTRL_ALU_OP_LSB +: 6] = op;
            c[CTRL_ALU_SRC]         = 1'b1;
            c[CTRL_MEM_RD]          = 1'b1;
            c[CTRL_REG_WR]          = 1'b1;
            c[CTRL_MEM_TO_REG]      = 1'b1;
            c[CTRL_BYTE]            = (op == OP_LB) || (op == OP_LBU);
            c[CTRL_HALF]            = (op == OP_LH) || (op == OP_LHU);
            c[CTRL_WORD]            = (op == OP_LW);
         end
         OP_SB, OP_SH, OP_SW: begin
            c[CTRL_ALU_OP_LSB +: 6] = op;
            c[CTRL_ALU_SRC]         = 1'b1;
            c[CTRL_MEM_WR]          = 1'b1;
            c[CTRL_BYTE]            = (op == OP_SB);
            c[CTRL_HALF]            = (op == OP_SH);
            c[CTRL_WORD]            = (op == OP_SW);
         end
         default: c = CTRL_BUBBLE;
      endcase
      return c;
   endfunction

   function automatic logic uses_rs(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_RTYPE: return rtype_known(fn) && !(fn == FN_SLL || fn == FN_SRL || fn == FN_SRA);
         OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
         OP_XORI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rt(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_RTYPE: return rtype_known(fn) && !(fn == FN_JR || fn == FN_JALR);
         OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic zero_ext_imm(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
   endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: 2 combinational read ports with write-through, 1 write port.
// r0 is hardwired to zero; async active-low reset clears every entry.
module id_regfile #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_we,
   input  logic [NB_REG-1:0]  i_waddr,
   input  logic [NB_DATA-1:0] i_wdata,
   input  logic [NB_REG-1:0]  i_raddr_a,
   input  logic [NB_REG-1:0]  i_raddr_b,
   output logic [NB_DATA-1:0] o_rdata_a,
   output logic [NB_DATA-1:0] o_rdata_b
);
   localparam int N_REGS = 2**NB_REG;

   logic [NB_DATA-1:0] regs_q [N_REGS];

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int r = 0; r < N_REGS; r++) regs_q[r] <= '0;
      end else if (i_we && (i_waddr != '0)) begin
         regs_q[i_waddr] <= i_wdata;
      end
   end

   // A write landing this cycle is visible to the decode reading it now.
   always_comb begin
      o_rdata_a = regs_q[i_raddr_a];
      if (i_raddr_a == '0)                        o_rdata_a = '0;
      else if (i_we && (i_waddr == i_raddr_a))    o_rdata_a = i_wdata;
      o_rdata_b = regs_q[i_raddr_b];
      if (i_raddr_b == '0)                        o_rdata_b = '0;
      else if (i_we && (i_waddr == i_raddr_b))    o_rdata_b = i_wdata;
   end

endmodule

// File: rtl/id_stage_hz.sv
// Decode stage with load-use stall/bubble and flush, registered ID/EX boundary.
// Optional ID_PERF_CNT_EN adds saturating stall/flush cycle counters.
module id_stage_hz
   import id_pkg::*;
#(
   parameter int NB_INST = 32,
   parameter int NB_PC   = 32,
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_flush,
   input  logic               i_valid,
   input  logic [NB_INST-1:0] i_inst,
   input  logic [NB_PC-1:0]   i_pc,
   input  logic               i_wb_reg_write,
   input  logic [NB_REG-1:0]  i_wb_write_reg,
   input  logic [NB_DATA-1:0] i_wb_write_data,
   input  logic               i_ex_mem_read,
   input  logic [NB_REG-1:0]  i_ex_rt,
   output logic               o_stall,
   output logic               o_valid,
   output logic [NB_CTRL-1:0] o_ctrl,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_DATA-1:0] o_immediate,
   output logic [NB_DATA-1:0] o_shamt,
   output logic [NB_REG-1:0]  o_rs,
   output logic [NB_REG-1:0]  o_rt,
   output logic [NB_REG-1:0]  o_rd,
   output logic [NB_PC-1:0]   o_pc,
   output logic [NB_PC-1:0]   o_jump_address
`ifdef ID_PERF_CNT_EN
   ,
   output logic [31:0]        o_stall_cnt,
   output logic [31:0]        o_flush_cnt
`endif
);

   logic [5:0]         op, fn;
   logic [NB_REG-1:0]  rs, rt, rd;
   logic [NB_DATA-1:0] rdata_a, rdata_b, imm_ext, shamt_ext;
   logic               hazard, load;

   assign op = i_inst[31:26];
   assign fn = i_inst[5:0];
   assign rs = i_inst[21 +: NB_REG];
   assign rt = i_inst[16 +: NB_REG];
   assign rd = i_inst[11 +: NB_REG];

   id_regfile #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) u_regfile (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_we      (i_enable & i_wb_reg_write),
      .i_waddr   (i_wb_write_reg),
      .i_wdata   (i_wb_write_data),
      .i_raddr_a (rs),
      .i_raddr_b (rt),
      .o_rdata_a (rdata_a),
      .o_rdata_b (rdata_b)
   );

   assign imm_ext   = zero_ext_imm(op) ? {{(NB_DATA-16){1'b0}}, i_inst[15:0]}
                                       : {{(NB_DATA-16){i_inst[15]}}, i_inst[15:0]};
   assign shamt_ext = {{(NB_DATA-5){1'b0}}, i_inst[10:6]};

   assign hazard  = i_valid & i_ex_mem_read & (i_ex_rt != '0) &
                    (((i_ex_rt == rs) & uses_rs(op, fn)) | ((i_ex_rt == rt) & uses_rt(op, fn)));
   // A flushed instruction is discarded anyway, so holding IF/ID for it is pointless.
   assign o_stall = hazard & ~i_flush & i_enable;
   assign load    = i_valid & ~i_flush & ~hazard;

   assign o_jump_address = {i_pc[NB_PC-1:26], i_inst[25:0]};

   logic               valid_d, valid_q;
   ctrl_t              ctrl_d, ctrl_q;
   logic [NB_DATA-1:0] data_a_d, data_a_q, data_b_d, data_b_q;
   logic [NB_DATA-1:0] imm_d, imm_q, shamt_d, shamt_q;
   logic [NB_REG-1:0]  rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
   logic [NB_PC-1:0]   pc_d, pc_q;

   always_comb begin
      valid_d  = 1'b0;
      ctrl_d   = CTRL_BUBBLE;
      data_a_d = '0;
      data_b_d = '0;
      imm_d    = '0;
      shamt_d  = '0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      pc_d     = '0;
      if (load) begin
         valid_d  = 1'b1;
         ctrl_d   = decode_ctrl(op, fn);
         data_a_d = rdata_a;
         data_b_d = rdata_b;
         imm_d    = imm_ext;
         shamt_d  = shamt_ext;
         rs_d     = rs;
         rt_d     = rt;
         rd_d     = rd;
         pc_d     = i_pc;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         valid_q  <= 1'b0;
         ctrl_q   <= CTRL_BUBBLE;
         data_a_q <= '0;
         data_b_q <= '0;
         imm_q    <= '0;
         shamt_q  <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         pc_q     <= '0;
      end else if (i_enable) begin
         valid_q  <= valid_d;
         ctrl_q   <= ctrl_d;
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
         imm_q    <= imm_d;
         shamt_q  <= shamt_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         pc_q     <= pc_d;
      end
   end

   assign o_valid     = valid_q;
   assign o_ctrl      = ctrl_q;
   assign o_data_a    = data_a_q;
   assign o_data_b    = data_b_q;
   assign o_immediate = imm_q;
   assign o_shamt     = shamt_q;
   assign o_rs        = rs_q;
   assign o_rt        = rt_q;
   assign o_rd        = rd_q;
   assign o_pc        = pc_q;

`ifdef ID_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (o_stall && (stall_cnt_q != '1))                 stall_cnt_q <= stall_cnt_q + 32'd1;
         if (i_enable && i_flush && (flush_cnt_q != '1))     flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_hz.sv
// Self-checking bench for id_stage_hz: vector table plus multi-cycle sequences.
module tb_id_stage_hz;

   logic        i_clock = 1'b0;
   logic        i_reset, i_enable, i_flush, i_valid;
   logic [31:0] i_inst, i_pc;
   logic        i_wb_reg_write;
   logic [4:0]  i_wb_write_reg;
   logic [31:0] i_wb_write_data;
   logic        i_ex_mem_read;
   logic [4:0]  i_ex_rt;
   logic        o_stall, o_valid;
   logic [17:0] o_ctrl;
   logic [31:0] o_data_a, o_data_b, o_immediate, o_shamt, o_pc, o_jump_address;
   logic [4:0]  o_rs, o_rt, o_rd;
`ifdef ID_PERF_CNT_EN
   logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

   int total = 0;
   int bad   = 0;

   id_stage_hz dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
      .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
      .i_wb_reg_write(i_wb_reg_write), .i_wb_write_reg(i_wb_write_reg),
      .i_wb_write_data(i_wb_write_data), .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
      .o_stall(o_stall), .o_valid(o_valid), .o_ctrl(o_ctrl), .o_data_a(o_data_a),
      .o_data_b(o_data_b), .o_immediate(o_immediate), .o_shamt(o_shamt),
      .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_pc(o_pc), .o_jump_address(o_jump_address)
`ifdef ID_PERF_CNT_EN
      , .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
`endif
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      logic        valid;
      logic        flush;
      logic        mem_read;
      logic [4:0]  ex_rt;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        exp_stall;
      logic        exp_valid;
      logic [17:0] exp_ctrl;
      logic [31:0] exp_a, exp_b, exp_imm, exp_sh;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   function automatic logic [31:0] r_enc(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_enc(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic add_vec(input logic valid, input logic flush, input logic mem_read,
                          input logic [4:0] ex_rt, input logic [31:0] inst, input logic [31:0] pc,
                          input logic exp_stall, input logic exp_valid, input logic [17:0] exp_ctrl,
                          input logic [31:0] exp_a, input logic [31:0] exp_b,
                          input logic [31:0] exp_imm, input logic [31:0] exp_sh);
      vec_t v;
      v.valid = valid; v.flush = flush; v.mem_read = mem_read; v.ex_rt = ex_rt;
      v.inst = inst; v.pc = pc; v.exp_stall = exp_stall; v.exp_valid = exp_valid;
      v.exp_ctrl = exp_ctrl; v.exp_a = exp_a; v.exp_b = exp_b;
      v.exp_imm = exp_imm; v.exp_sh = exp_sh;
      vecs.push_back(v);
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
      i_wb_reg_write = 1'b1; i_wb_write_reg = r; i_wb_write_data = d;
      tick();
      i_wb_reg_write = 1'b0;
   endtask

   task automatic drive(input logic valid, input logic [31:0] inst, input logic [31:0] pc);
      i_valid = valid; i_inst = inst; i_pc = pc;
   endtask

   initial begin
      logic [31:0] add412, add431, add413, add401;
      vec_t v;

      add412 = r_enc(5'd1, 5'd2, 5'd4, 5'd0, 6'h20);
      add431 = r_enc(5'd3, 5'd1, 5'd4, 5'd0, 6'h20);
      add413 = r_enc(5'd1, 5'd3, 5'd4, 5'd0, 6'h20);
      add401 = r_enc(5'd0, 5'd1, 5'd4, 5'd0, 6'h20);

      // valid flush mrd ex_rt inst pc | stall valid ctrl a b imm shamt
      add_vec(1, 0, 0, 0, add412, 32'h100, 0, 1, 18'h30040, 32'h11, 32'h22, 32'h2020, 0);
      add_vec(1, 0, 0, 0, i_enc(6'h0D, 5'd1, 5'd6, 16'h8000), 32'h101, 0, 1, 18'h06C40, 32'h11, 0, 32'h00008000, 0);
      add_vec(1, 0, 0, 0, i_enc(6'h08, 5'd2, 5'd7, 16'h8000), 32'h102, 0, 1, 18'h04440, 32'h22, 0, 32'hFFFF8000, 0);
      add_vec(1, 0, 0, 0, i_enc(6'h23, 5'd3, 5'd8, 16'h0004), 32'h103, 0, 1, 18'h11E61, 32'h33, 0, 32'h4, 0);
      add_vec(1, 0, 0, 0, i_enc(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h104, 0, 1, 18'h15D01, 32'h11, 32'h22, 32'h8, 0);
      add_vec(1, 0, 0, 0, i_enc(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'h105, 0, 1, 18'h02080, 32'h11, 32'h22, 32'hFFFFFFFF, 32'h1F);
      add_vec(1, 0, 0, 0, {6'h02, 26'h123}, 32'h106, 0, 1, 18'h01010, 0, 0, 32'h123, 32'h4);
      add_vec(1, 0, 0, 0, r_enc(5'd0, 5'd2, 5'd9, 5'd5, 6'h00), 32'h107, 0, 1, 18'h20040, 0, 32'h22, 32'h4940, 32'h5);
      add_vec(1, 0, 0, 0, i_enc(6'h3F, 5'd1, 5'd2, 16'h0000), 32'h108, 0, 1, 18'h0, 32'h11, 32'h22, 0, 0);
      add_vec(0, 0, 0, 0, add412, 32'h109, 0, 0, 18'h0, 0, 0, 0, 0);
      add_vec(1, 1, 0, 0, add412, 32'h10A, 0, 0, 18'h0, 0, 0, 0, 0);
      add_vec(1, 0, 1, 3, add431, 32'h10B, 1, 0, 18'h0, 0, 0, 0, 0);
      add_vec(1, 0, 0, 0, add431, 32'h10B, 0, 1, 18'h30040, 32'h33, 32'h11, 32'h2020, 0);
      add_vec(1, 0, 1, 3, add413, 32'h10C, 1, 0, 18'h0, 0, 0, 0, 0);
      add_vec(1, 0, 1, 3, i_enc(6'h0D, 5'd1, 5'd3, 16'h0005), 32'h10D, 0, 1, 18'h06C40, 32'h11, 32'h33, 32'h5, 0);
      add_vec(1, 0, 1, 0, add401, 32'h10E, 0, 1, 18'h30040, 0, 32'h11, 32'h2020, 0);
      add_vec(1, 1, 1, 3, add431, 32'h10F, 0, 0, 18'h0, 0, 0, 0, 0);
      add_vec(0, 0, 1, 3, add431, 32'h110, 0, 0, 18'h0, 0, 0, 0, 0);
      add_vec(1, 0, 1, 3, i_enc(6'h2B, 5'd1, 5'd3, 16'h0000), 32'h111, 1, 0, 18'h0, 0, 0, 0, 0);

      // clock/reset
      i_reset = 1'b0; i_enable = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
      i_inst = '0; i_pc = '0; i_wb_reg_write = 1'b0; i_wb_write_reg = '0;
      i_wb_write_data = '0; i_ex_mem_read = 1'b0; i_ex_rt = '0;
      #2;
      check("rst_valid", {31'd0, o_valid}, 0);
      check("rst_ctrl", {14'd0, o_ctrl}, 0);
      check("rst_data_a", o_data_a, 0);
      check("rst_pc", o_pc, 0);
`ifdef ID_PERF_CNT_EN
      check("rst_stall_cnt", o_stall_cnt, 0);
      check("rst_flush_cnt", o_flush_cnt, 0);
`endif
      @(negedge i_clock);
      i_reset = 1'b1;

      wb_write(5'd1, 32'h11);
      wb_write(5'd2, 32'h22);
      wb_write(5'd3, 32'h33);
      wb_write(5'd0, 32'hDEAD);

      for (int k = 0; k < vecs.size(); k++) begin
         v = vecs[k];
         i_flush = v.flush; i_ex_mem_read = v.mem_read; i_ex_rt = v.ex_rt;
         drive(v.valid, v.inst, v.pc);
         #1;
         check($sformatf("v%0d_stall", k), {31'd0, o_stall}, {31'd0, v.exp_stall});
         tick();
         check($sformatf("v%0d_valid", k), {31'd0, o_valid}, {31'd0, v.exp_valid});
         check($sformatf("v%0d_ctrl", k), {14'd0, o_ctrl}, {14'd0, v.exp_ctrl});
         check($sformatf("v%0d_a", k), o_data_a, v.exp_a);
         check($sformatf("v%0d_b", k), o_data_b, v.exp_b);
         check($sformatf("v%0d_imm", k), o_immediate, v.exp_valid ? v.exp_imm : 32'h0);
         check($sformatf("v%0d_shamt", k), o_shamt, v.exp_valid ? v.exp_sh : 32'h0);
         check($sformatf("v%0d_rs", k), {27'd0, o_rs}, v.exp_valid ? {27'd0, v.inst[25:21]} : 32'h0);
         check($sformatf("v%0d_rt", k), {27'd0, o_rt}, v.exp_valid ? {27'd0, v.inst[20:16]} : 32'h0);
         check($sformatf("v%0d_rd", k), {27'd0, o_rd}, v.exp_valid ? {27'd0, v.inst[15:11]} : 32'h0);
         check($sformatf("v%0d_pc", k), o_pc, v.exp_valid ? v.pc : 32'h0);
      end
      i_flush = 1'b0; i_ex_mem_read = 1'b0; i_ex_rt = '0;

      // WB write-through to r5 while ADD reads it; r0 write-through must stay 0
      drive(1, r_enc(5'd5, 5'd1, 5'd4, 5'd0, 6'h20), 32'h200);
      wb_write(5'd5, 32'hA5);
      check("wt_a", o_data_a, 32'hA5);
      check("wt_b", o_data_b, 32'h11);
      drive(1, r_enc(5'd5, 5'd0, 5'd4, 5'd0, 6'h20), 32'h201);
      wb_write(5'd0, 32'hFF);
      check("wt_r5_kept", o_data_a, 32'hA5);
      check("wt_r0", o_data_b, 32'h0);

      // jump address from IF/ID PC upper bits and target
      drive(1, {6'h02, 26'h123}, 32'h0400_0100);
      #1;
      check("jaddr_0", o_jump_address, 32'h0400_0123);
      drive(1, {6'h03, 26'h3FF_FFFF}, 32'hFC00_0000);
      #1;
      check("jaddr_1", o_jump_address, 32'hFFFF_FFFF);

      // freeze: 3 cycles with enable low, changing inputs, hazard, flush and a WB write
      drive(1, add412, 32'h300);
      tick();
      check("frz_pre_valid", {31'd0, o_valid}, 1);
      i_enable = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(c[0], add431 + c, 32'h310 + c);
         i_ex_mem_read = 1'b1; i_ex_rt = 5'd3; i_flush = (c == 2);
         i_wb_reg_write = 1'b1; i_wb_write_reg = 5'd10; i_wb_write_data = 32'h77;
         #1;
         check($sformatf("frz%0d_stall", c), {31'd0, o_stall}, 0);
         tick();
         check($sformatf("frz%0d_valid", c), {31'd0, o_valid}, 1);
         check($sformatf("frz%0d_ctrl", c), {14'd0, o_ctrl}, 32'h30040);
         check($sformatf("frz%0d_a", c), o_data_a, 32'h11);
         check($sformatf("frz%0d_b", c), o_data_b, 32'h22);
         check($sformatf("frz%0d_pc", c), o_pc, 32'h300);
      end
      i_enable = 1'b1; i_wb_reg_write = 1'b0; i_ex_mem_read = 1'b0; i_ex_rt = '0; i_flush = 1'b0;
      drive(1, r_enc(5'd10, 5'd0, 5'd4, 5'd0, 6'h20), 32'h320);
      tick();
      check("frz_wb_suppressed", o_data_a, 32'h0);
      check("frz_post_valid", {31'd0, o_valid}, 1);

      // asynchronous reset between edges
      drive(1, add412, 32'h400);
      tick();
      check("ar_pre_a", o_data_a, 32'h11);
      #2;
      i_reset = 1'b0;
      #1;
      check("ar_valid", {31'd0, o_valid}, 0);
      check("ar_ctrl", {14'd0, o_ctrl}, 0);
      check("ar_a", o_data_a, 0);
      check("ar_b", o_data_b, 0);
      check("ar_pc", o_pc, 0);
`ifdef ID_PERF_CNT_EN
      check("ar_stall_cnt", o_stall_cnt, 0);
      check("ar_flush_cnt", o_flush_cnt, 0);
`endif
      #1;
      i_reset = 1'b1;
      tick();
      check("ar_regs_a", o_data_a, 0);
      check("ar_regs_b", o_data_b, 0);
      check("ar_post_valid", {31'd0, o_valid}, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
